// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Holds the address-field widths, line geometry and the controller state
// encoding used by dcache_ctrl and dcache_sram.
package dcache_pkg;

   localparam int TAG_W    = 22;
   localparam int INDEX_W  = 5;
   localparam int OFFSET_W = 5;
   localparam int LINE_W   = 256;
   localparam int WORD_W   = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2,
      RETRY     = 2'd3
   } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the direct-mapped data cache: per-line valid, dirty, tag
// and data. One write port, asynchronous read, both addressed by idx.
// Ports:
//   clk_i, rst_i        clock, async active-low reset (clears valid/dirty only)
//   idx                 line index for both read and write
//   rd_valid/rd_dirty   status bits of the indexed line
//   rd_tag/rd_line      tag and data of the indexed line
//   we                  write enable: line becomes valid with wr_tag/wr_line
//   wr_dirty            dirty bit written alongside the line
module dcache_sram #(
   parameter int INDEX_W = 5,
   parameter int TAG_W   = 22,
   parameter int LINE_W  = 256
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] idx,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               we,
   input  logic               wr_dirty,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line
);

   localparam int LINES = 2 ** INDEX_W;

   logic [LINES-1:0]  valid_r;
   logic [LINES-1:0]  dirty_r;
   logic [TAG_W-1:0]  tag_r  [LINES];
   logic [LINE_W-1:0] data_r [LINES];

   // Status bits: cleared by reset so every line starts invalid and clean
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_r <= '0;
         dirty_r <= '0;
      end else if (we) begin
         valid_r[idx] <= 1'b1;
         dirty_r[idx] <= wr_dirty;
      end
   end

   // Tag and data arrays: no reset, contents are qualified by valid_r
   always_ff @(posedge clk_i) begin
      if (we) begin
         tag_r[idx]  <= wr_tag;
         data_r[idx] <= wr_line;
      end
   end

   assign rd_valid = valid_r[idx];
   assign rd_dirty = dirty_r[idx];
   assign rd_tag   = tag_r[idx];
   assign rd_line  = data_r[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// A hit is served combinationally in the access cycle; a miss stalls the CPU
// while the dirty victim is written back (if any) and the line is filled,
// then one RETRY cycle lets the access complete as a hit.
// Ports:
//   clk_i, rst_i                       clock, async active-low reset
//   p1_req_i/p1_wr_i/p1_addr_i/p1_wdata_i  CPU access (held while stalled)
//   p1_rdata_o, p1_stall_o             load data, pipeline stall
//   mem_req_o/mem_wr_o/mem_addr_o/mem_wdata_o  line request to memory
//   mem_ack_i, mem_rdata_i             one-cycle completion, fill data
//   hit_cnt_o, miss_cnt_o              access statistics (wrapping)
module dcache_ctrl #(
   parameter int INDEX_W = 5,
   parameter int LINE_W  = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic              p1_wr_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_wdata_i,
   output logic [31:0]       p1_rdata_o,
   output logic              p1_stall_o,
   output logic              mem_req_o,
   output logic              mem_wr_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_rdata_i,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);

   import dcache_pkg::*;

   localparam int TAG_BITS = 32 - INDEX_W - OFFSET_W;
   localparam int WSEL_W   = OFFSET_W - 2;

   state_t              state_r, state_n;
   logic                mem_req_r, mem_req_n;
   logic                mem_wr_r, mem_wr_n;
   logic [31:0]         mem_addr_r, mem_addr_n;
   logic [LINE_W-1:0]   mem_wdata_r, mem_wdata_n;
   logic                after_retry_r;
   logic [31:0]         hit_cnt_r;
   logic [31:0]         miss_cnt_r;

   logic [INDEX_W-1:0]  idx_s;
   logic [TAG_BITS-1:0] tag_s;
   logic [WSEL_W-1:0]   wsel_s;
   logic [WSEL_W+4:0]   bit_base_s;
   logic                rd_valid_s;
   logic                rd_dirty_s;
   logic [TAG_BITS-1:0] rd_tag_s;
   logic [LINE_W-1:0]   rd_line_s;
   logic                hit_s;
   logic                miss_s;
   logic                victim_dirty_s;
   logic [31:0]         victim_addr_s;
   logic [31:0]         fill_addr_s;
   logic                count_hit_s;
   logic                count_miss_s;
   logic                sram_we_s;
   logic                sram_dirty_s;
   logic [TAG_BITS-1:0] sram_tag_s;
   logic [LINE_W-1:0]   sram_line_s;
   logic                unused_s;

   assign idx_s      = p1_addr_i[OFFSET_W +: INDEX_W];
   assign tag_s      = p1_addr_i[31 -: TAG_BITS];
   assign wsel_s     = p1_addr_i[OFFSET_W-1:2];
   assign bit_base_s = {wsel_s, 5'd0};
   // Byte offset within a word is not used: accesses are whole words
   assign unused_s   = ^p1_addr_i[1:0];

   dcache_sram #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_BITS),
      .LINE_W  (LINE_W)
   ) u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .idx      (idx_s),
      .rd_valid (rd_valid_s),
      .rd_dirty (rd_dirty_s),
      .rd_tag   (rd_tag_s),
      .rd_line  (rd_line_s),
      .we       (sram_we_s),
      .wr_dirty (sram_dirty_s),
      .wr_tag   (sram_tag_s),
      .wr_line  (sram_line_s)
   );

   assign hit_s          = p1_req_i & rd_valid_s & (rd_tag_s == tag_s);
   assign miss_s         = p1_req_i & ~hit_s;
   assign victim_dirty_s = rd_valid_s & rd_dirty_s;
   assign victim_addr_s  = {rd_tag_s, idx_s, {OFFSET_W{1'b0}}};
   assign fill_addr_s    = {tag_s, idx_s, {OFFSET_W{1'b0}}};

   // The access that completes right after RETRY was already counted as a miss
   assign count_hit_s  = (state_r == IDLE) & hit_s & ~after_retry_r;
   assign count_miss_s = (state_r == IDLE) & miss_s;

   // Stall and load data must act in the access cycle, so they are not registered
   assign p1_stall_o = (state_r != IDLE) | miss_s;
   assign p1_rdata_o = rd_line_s[bit_base_s +: WORD_W];

   // Next state, storage write port and next memory-request fields
   always_comb begin
      state_n      = state_r;
      mem_req_n    = mem_req_r;
      mem_wr_n     = mem_wr_r;
      mem_addr_n   = mem_addr_r;
      mem_wdata_n  = mem_wdata_r;
      sram_we_s    = 1'b0;
      sram_dirty_s = 1'b0;
      sram_tag_s   = tag_s;
      sram_line_s  = rd_line_s;
      case (state_r)
         IDLE: begin
            if (miss_s) begin
               mem_req_n   = 1'b1;
               mem_wr_n    = victim_dirty_s;
               mem_wdata_n = rd_line_s;
               if (victim_dirty_s) begin
                  state_n    = WRITEBACK;
                  mem_addr_n = victim_addr_s;
               end else begin
                  state_n    = FILL;
                  mem_addr_n = fill_addr_s;
               end
            end else if (hit_s && p1_wr_i) begin
               sram_we_s    = 1'b1;
               sram_dirty_s = 1'b1;
               sram_line_s[bit_base_s +: WORD_W] = p1_wdata_i;
            end else begin
               state_n = IDLE;
            end
         end
         WRITEBACK: begin
            if (mem_ack_i) begin
               state_n    = FILL;
               mem_wr_n   = 1'b0;
               mem_addr_n = fill_addr_s;
            end else begin
               state_n = WRITEBACK;
            end
         end
         FILL: begin
            if (mem_ack_i) begin
               state_n      = RETRY;
               mem_req_n    = 1'b0;
               sram_we_s    = 1'b1;
               sram_dirty_s = 1'b0;
               sram_line_s  = mem_rdata_i;
            end else begin
               state_n = FILL;
            end
         end
         RETRY: begin
            state_n = IDLE;
         end
         default: begin
            state_n   = IDLE;
            mem_req_n = 1'b0;
            mem_wr_n  = 1'b0;
         end
      endcase
   end

   // State, memory-request registers and statistics counters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r       <= IDLE;
         mem_req_r     <= 1'b0;
         mem_wr_r      <= 1'b0;
         mem_addr_r    <= 32'd0;
         mem_wdata_r   <= '0;
         after_retry_r <= 1'b0;
         hit_cnt_r     <= 32'd0;
         miss_cnt_r    <= 32'd0;
      end else begin
         state_r       <= state_n;
         mem_req_r     <= mem_req_n;
         mem_wr_r      <= mem_wr_n;
         mem_addr_r    <= mem_addr_n;
         mem_wdata_r   <= mem_wdata_n;
         after_retry_r <= (state_r == RETRY);
         if (count_hit_s) begin
            hit_cnt_r <= hit_cnt_r + 32'd1;
         end
         if (count_miss_s) begin
            miss_cnt_r <= miss_cnt_r + 32'd1;
         end
      end
   end

   assign mem_req_o   = mem_req_r;
   assign mem_wr_o    = mem_wr_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_wdata_o = mem_wdata_r;
   assign hit_cnt_o   = hit_cnt_r;
   assign miss_cnt_o  = miss_cnt_r;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 5, SHALL set line count to 2**INDEX_W (32 lines).
REQ-002 Parameter LINE_W, default 256, SHALL set line width in bits (32 bytes, 8 words).
REQ-003 clk_i  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_i  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 p1_req_i  input  1  CPU MEM-stage access valid (load or store).
REQ-006 p1_wr_i  input  1  1 = store, 0 = load.
REQ-007 p1_addr_i  input  32  byte address; [4:0] offset, [9:5] index, [31:10] tag (22 bits).
REQ-008 p1_wdata_i  input  32  store data.
REQ-009 p1_rdata_o  output  32  load data, valid when p1_req_i=1 and p1_stall_o=0.
REQ-010 p1_stall_o  output  1  freezes all CPU pipeline registers and PC while 1.
REQ-011 mem_req_o  output  1  memory request.
REQ-012 mem_wr_o  output  1  1 = line write-back, 0 = line fill.
REQ-013 mem_addr_o  output  32  line-aligned address, [4:0]=0.
REQ-014 mem_wdata_o  output  LINE_W  write-back line.
REQ-015 mem_ack_i  input  1  one-cycle completion pulse from memory.
REQ-016 mem_rdata_i  input  LINE_W  fill line, valid in the mem_ack_i cycle.
REQ-017 hit_cnt_o / miss_cnt_o  output  32 each  access statistics.

Function
REQ-018 Storage SHALL be direct-mapped: per line valid bit, dirty bit, 22-bit tag, LINE_W data.
REQ-019 Hit SHALL be combinational: p1_req_i & valid[index] & (tag[index]==p1_addr_i[31:10]).
REQ-020 Load hit: p1_rdata_o SHALL be word p1_addr_i[4:2] of the line in the same cycle, p1_stall_o=0.
REQ-021 Store hit: selected word SHALL be written and dirty set at the next edge, p1_stall_o=0; byte offset [1:0] ignored.
REQ-022 FSM states IDLE, WRITEBACK, FILL, RETRY; encoding fixed in package.
REQ-023 IDLE: miss with clean/invalid victim -> FILL; miss with dirty victim -> WRITEBACK; p1_stall_o=1 from the miss cycle.
REQ-024 WRITEBACK: mem_req_o=1, mem_wr_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line; on mem_ack_i -> FILL.
REQ-025 FILL: mem_req_o=1, mem_wr_o=0, mem_addr_o={p1 tag, index, 5'b0}; on mem_ack_i the line SHALL be loaded, valid=1, dirty=0, tag updated -> RETRY.
REQ-026 RETRY: one cycle, p1_stall_o=1, mem_req_o=0; -> IDLE, where the access completes as a hit.
REQ-027 mem_req_o and all mem_* request fields SHALL stay constant from assertion until the mem_ack_i cycle inclusive; mem_req_o SHALL drop the cycle after ack.
REQ-028 p1_stall_o SHALL be 1 in WRITEBACK, FILL, RETRY and in IDLE on a miss; 0 otherwise.
REQ-029 p1_req_i=0 in IDLE SHALL cause no state, storage or counter change.
REQ-030 hit_cnt_o SHALL increment once per completed access (including post-RETRY completion is NOT counted); miss_cnt_o once per IDLE->WRITEBACK/FILL transition; both wrap at 2**32.
REQ-031 mem_ack_i in IDLE or RETRY SHALL be ignored.
REQ-032 CPU inputs SHALL be held stable by the CPU while p1_stall_o=1; controller SHALL not latch them.

Reset
REQ-033 rst_i=0 SHALL immediately force state=IDLE, all valid and dirty bits 0, hit_cnt_o=miss_cnt_o=0, mem_req_o=0, mem_wr_o=0.
REQ-034 Reset mid-WRITEBACK/FILL SHALL abandon the transfer; mem_req_o=0 asynchronously; tag/data arrays need not be reset.
REQ-035 After reset release, p1_stall_o SHALL be 0 unless p1_req_i=1 (every access misses).

Structure
REQ-036 Package dcache_pkg SHALL hold state encoding, TAG_W=22, INDEX_W, OFFSET_W=5, LINE_W.
REQ-037 Storage SHALL be a sub-module dcache_sram (tag/valid/dirty/data arrays, one write port, async read); FSM and counters stay in dcache_ctrl.

Verification
REQ-038 Reset, load 0x0000_0040 -> miss, FILL addr 0x40, ack after 3 cycles, RETRY, data word 0 returned, miss_cnt=1.
REQ-039 Store 0xDEADBEEF to 0x44 after fill -> no stall, dirty[2]=1; load 0x44 -> 0xDEADBEEF, hit_cnt=2.
REQ-040 Load 0x0000_0440 (same index 2, different tag) -> WRITEBACK addr 0x40 with 0xDEADBEEF in word 1, then FILL addr 0x440.
REQ-041 Hold mem_ack_i low 20 cycles in FILL -> mem_req_o and mem_addr_o constant, p1_stall_o=1 throughout.
REQ-042 Assert rst_i=0 during WRITEBACK -> mem_req_o=0 same cycle, state IDLE, repeat load 0x40 misses.
REQ-043 Spurious mem_ack_i in IDLE with p1_req_i=0 -> no state, array or counter change.
